ps2_param_loader: RTL and testbench

//  Loads a parametrised bank of programmable gain registers from PS/2 scan codes.

---
 rtl/ps2_param_loader.sv | 171 +++++++++++++++++
 tb/tb_ps2_param_loader.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_param_loader.sv
// PS/2 keypad loader for a bank of programmable gain registers.
// Decimal digits accumulate into a pending entry (Backspace removes the last
// digit, Esc drops the entry) and Enter commits the saturated value to the
// channel selected by ch_sel. Break sequences (F0 xx) are swallowed so that a
// key release never acts as a keystroke.
//
//  state    | meaning
//  ---------+----------------------------------------------------------
//  ST_MAKE  | decode incoming bytes as key presses
//  ST_BREAK | F0 seen; the next byte is the released key and is dropped
module ps2_param_loader #(
    parameter int N_CH       = 3,
    parameter int W          = 2,
    parameter int MAX_DIGITS = 3,
    parameter int ACC_W      = 10,
    parameter int CH_W       = 2,
    parameter int DC_W       = $clog2(MAX_DIGITS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_done_tick,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic              clr,
    output logic [N_CH*W-1:0] gains,
    output logic              wr_tick,
    output logic              err_tick,
    output logic              entry_active,
    output logic [DC_W-1:0]   digit_cnt
);

    localparam logic [7:0] KEY_BREAK = 8'hF0;
    localparam logic [7:0] KEY_EXT   = 8'hE0;
    localparam logic [7:0] KEY_ENTER = 8'h5A;
    localparam logic [7:0] KEY_ESC   = 8'h76;
    localparam logic [7:0] KEY_BS    = 8'h66;
    localparam int         MAX_GAIN  = (2 ** W) - 1;

    typedef enum logic {
        ST_MAKE  = 1'b0,
        ST_BREAK = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [DC_W-1:0]     cnt_q, cnt_d;
    logic [N_CH*W-1:0]   gains_q, gains_d;
    logic                wr_q, wr_d;
    logic                err_q, err_d;

    logic                dig_vld;
    logic [3:0]          dig_val;
    logic [W-1:0]        sat_val;
    logic                ch_ok;

    // Map set-2 make codes of the number row to their decimal value.
    always_comb begin
        dig_vld = 1'b1;
        dig_val = 4'd0;
        case (rx_data)
            8'h45:   dig_val = 4'd0;
            8'h16:   dig_val = 4'd1;
            8'h1E:   dig_val = 4'd2;
            8'h26:   dig_val = 4'd3;
            8'h25:   dig_val = 4'd4;
            8'h2E:   dig_val = 4'd5;
            8'h36:   dig_val = 4'd6;
            8'h3D:   dig_val = 4'd7;
            8'h3E:   dig_val = 4'd8;
            8'h46:   dig_val = 4'd9;
            default: dig_vld = 1'b0;
        endcase
    end

    // Value committed on Enter: the entry clamped to the register range.
    always_comb begin
        sat_val = acc_q[W-1:0];
        if (acc_q > ACC_W'(MAX_GAIN)) begin
            sat_val = '1;
        end
        ch_ok = (int'(ch_sel) < N_CH);
    end

    // Next-state logic: clr wins over any byte, BREAK swallows one byte.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        gains_d = gains_q;
        wr_d    = 1'b0;
        err_d   = 1'b0;
        if (clr) begin
            state_d = ST_MAKE;
            acc_d   = '0;
            cnt_d   = '0;
            gains_d = '0;
        end else if (rx_done_tick) begin
            if (state_q == ST_BREAK) begin
                state_d = ST_MAKE;
            end else if (rx_data == KEY_BREAK) begin
                state_d = ST_BREAK;
            end else if (dig_vld) begin
                if (cnt_q < DC_W'(MAX_DIGITS)) begin
                    acc_d = (acc_q * ACC_W'(10)) + ACC_W'(dig_val);
                    cnt_d = cnt_q + DC_W'(1);
                end
            end else begin
                case (rx_data)
                    KEY_BS: begin
                        if (cnt_q != '0) begin
                            acc_d = acc_q / ACC_W'(10);
                            cnt_d = cnt_q - DC_W'(1);
                        end
                    end
                    KEY_ESC: begin
                        acc_d = '0;
                        cnt_d = '0;
                    end
                    KEY_ENTER: begin
                        if (cnt_q != '0) begin
                            if (ch_ok) begin
                                for (int k = 0; k < N_CH; k++) begin
                                    if (int'(ch_sel) == k) begin
                                        gains_d[k*W +: W] = sat_val;
                                    end
                                end
                                wr_d = 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                            acc_d = '0;
                            cnt_d = '0;
                        end
                    end
                    KEY_EXT: begin
                        state_d = state_q;
                    end
                    default: begin
                        state_d = state_q;
                    end
                endcase
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_MAKE;
            acc_q   <= '0;
            cnt_q   <= '0;
            gains_q <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            gains_q <= gains_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
        end
    end

    assign gains        = gains_q;
    assign wr_tick      = wr_q;
    assign err_tick     = err_q;
    assign digit_cnt    = cnt_q;
    assign entry_active = (cnt_q != '0);

endmodule

// File: tb/tb_ps2_param_loader.sv
// Bench for ps2_param_loader: directed key sequences followed by random
// traffic, every cycle compared against a digit-queue model of the loader.
module tb_ps2_param_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done_tick = 1'b0;
    logic [1:0] ch_sel = 2'd0;
    logic       clr = 1'b0;
    logic [5:0] gains;
    logic       wr_tick;
    logic       err_tick;
    logic       entry_active;
    logic [1:0] digit_cnt;

    ps2_param_loader dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_done_tick (rx_done_tick),
        .ch_sel       (ch_sel),
        .clr          (clr),
        .gains        (gains),
        .wr_tick      (wr_tick),
        .err_tick     (err_tick),
        .entry_active (entry_active),
        .digit_cnt    (digit_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: pending digits as a list, gains as plain integers.
    int m_digits[$];
    int m_gain[3];
    bit m_brk;
    int m_wr;
    int m_err;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    int codes[16] = '{'h45, 'h16, 'h1E, 'h26, 'h25, 'h2E, 'h36, 'h3D,
                      'h3E, 'h46, 'h5A, 'h76, 'h66, 'hF0, 'hE0, 'h11};

    function automatic int digit_of(input int code);
        int map[10] = '{'h45, 'h16, 'h1E, 'h26, 'h25, 'h2E, 'h36, 'h3D, 'h3E, 'h46};
        for (int i = 0; i < 10; i++) if (map[i] == code) return i;
        return -1;
    endfunction

    function automatic int entry_value();
        int v = 0;
        foreach (m_digits[i]) v = v * 10 + m_digits[i];
        return v;
    endfunction

    function automatic int flat_gains();
        return m_gain[0] + (m_gain[1] << 2) + (m_gain[2] << 4);
    endfunction

    task automatic model_reset();
        m_digits.delete();
        m_gain = '{0, 0, 0};
        m_brk = 1'b0;
        m_wr = 0;
        m_err = 0;
    endtask

    task automatic model_step(input bit vld, input int code, input int ch, input bit c);
        int d;
        int v;
        m_wr = 0;
        m_err = 0;
        if (c) begin
            m_digits.delete();
            m_gain = '{0, 0, 0};
            m_brk = 1'b0;
        end else if (vld) begin
            d = digit_of(code);
            if (m_brk) m_brk = 1'b0;
            else if (code == 'hF0) m_brk = 1'b1;
            else if (d >= 0) begin
                if (m_digits.size() < 3) m_digits.push_back(d);
            end else if (code == 'h66) begin
                if (m_digits.size() > 0) void'(m_digits.pop_back());
            end else if (code == 'h76) begin
                m_digits.delete();
            end else if (code == 'h5A && m_digits.size() > 0) begin
                v = entry_value();
                if (v > 3) v = 3;
                if (ch < 3) begin
                    m_gain[ch] = v;
                    m_wr = 1;
                end else begin
                    m_err = 1;
                end
                m_digits.delete();
            end
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".gains"}, int'(gains), flat_gains());
        chk({tag, ".wr_tick"}, int'(wr_tick), m_wr);
        chk({tag, ".err_tick"}, int'(err_tick), m_err);
        chk({tag, ".digit_cnt"}, int'(digit_cnt), m_digits.size());
        chk({tag, ".entry_active"}, int'(entry_active), int'(m_digits.size() > 0));
    endtask

    // One clock: inputs applied just after an edge, outputs checked #1 after the next.
    task automatic cyc(input bit vld, input int code, input int ch, input bit c, input string tag);
        rx_done_tick = vld;
        rx_data = 8'(code);
        ch_sel = 2'(ch);
        clr = c;
        @(posedge clk);
        #1;
        model_step(vld, code, ch, c);
        check_all(tag);
        rx_done_tick = 1'b0;
        clr = 1'b0;
    endtask

    task automatic keys(input int seq[$], input int ch, input string tag);
        foreach (seq[i]) cyc(1'b1, seq[i], ch, 1'b0, tag);
        cyc(1'b0, 0, ch, 1'b0, {tag, ".idle"});
    endtask

    initial begin
        int code;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        keys('{'h16, 'h5A}, 0, "t1_enter_ch0");
        keys('{'h1E, 'hF0, 'h1E, 'h26, 'h5A}, 2, "t2_break_sat");
        keys('{'h26, 'h25, 'h66, 'h5A}, 1, "t3_backspace");
        keys('{'h16, 'h16, 'h16, 'h16}, 0, "t4_overflow");
        keys('{'h76}, 0, "t4_esc");
        keys('{'h1E, 'h5A}, 3, "t5_bad_ch");
        keys('{'h5A, 'hE0, 'h11, 'h66}, 0, "t5b_noops");
        cyc(1'b1, 'h3E, 1, 1'b0, "t6_digit");
        cyc(1'b1, 'h5A, 1, 1'b1, "t6_enter_clr");
        cyc(1'b0, 0, 1, 1'b0, "t6_after_clr");

        keys('{'h36, 'h5A, 'h25, 'hF0}, 1, "t6_pre_rst");
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("t6_async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        keys('{'h45, 'h16, 'h5A}, 2, "t6_post_rst");

        for (int i = 0; i < 600; i++) begin
            code = codes[$urandom_range(15)];
            cyc(1'($urandom_range(3) != 0), code, int'($urandom_range(3)),
                1'($urandom_range(39) == 0), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
